// File: rtl/ddr_sched_pkg.sv
// Shared types and constants for the DDR2 command scheduler.
//   cmd_t       : scheduler command selection
//   RCW_*       : {ras_n, cas_n, we_n} encodings per command
//   *_W         : DFI / address / timing field widths
//   A10_BIT     : auto-precharge / all-bank address bit
package ddr_sched_pkg;

  localparam int unsigned RA_W    = 14;
  localparam int unsigned CA_W    = 10;
  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned BA_W    = 3;
  localparam int unsigned T_W     = 4;
  localparam int unsigned A10_BIT = 10;

  typedef enum logic [2:0] {NOP, ACT, RD, WR, PRE, REF} cmd_t;

  localparam logic [2:0] RCW_NOP = 3'b111;
  localparam logic [2:0] RCW_ACT = 3'b011;
  localparam logic [2:0] RCW_RD  = 3'b101;
  localparam logic [2:0] RCW_WR  = 3'b100;
  localparam logic [2:0] RCW_PRE = 3'b010;
  localparam logic [2:0] RCW_REF = 3'b001;

  // {ras_n, cas_n, we_n} for a command
  function automatic logic [2:0] cmd_rcw(input cmd_t cmd);
    case (cmd)
      ACT:     return RCW_ACT;
      RD:      return RCW_RD;
      WR:      return RCW_WR;
      PRE:     return RCW_PRE;
      REF:     return RCW_REF;
      default: return RCW_NOP;
    endcase
  endfunction

  // Counter load value max(t-1, 0): t of 0 or 1 allows back-to-back
  function automatic logic [T_W-1:0] t_load(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - T_W'(1);
  endfunction

endpackage

// File: rtl/ddr_cmd_scheduler_if.sv
// Bank-controller side of the scheduler: per-bank requests, grants and addresses.
//   master : bank controllers (drive req/ra/ca, receive gnt)
//   slave  : scheduler (receive req/ra/ca, drive gnt)
interface ddr_cmd_scheduler_if
  import ddr_sched_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 4
);
  logic [NUM_BANKS-1:0]      act_req, rd_req, wr_req, pre_req, ref_req;
  logic [NUM_BANKS-1:0]      act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [NUM_BANKS*RA_W-1:0] ra;
  logic [NUM_BANKS*CA_W-1:0] ca;

  modport master (
    output act_req, rd_req, wr_req, pre_req, ref_req, ra, ca,
    input  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt
  );

  modport slave (
    input  act_req, rd_req, wr_req, pre_req, ref_req, ra, ca,
    output act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt
  );
endinterface

// File: rtl/ddr_sched_rr_arb.sv
// Round-robin arbiter over NUM_BANKS requesters.
//   req_i    : eligible request mask
//   adv_i    : class was granted this cycle; pointer moves to winner+1
//   gnt_c_o  : one-hot winner (combinational)
//   idx_c_o  : winner index (combinational)
module ddr_sched_rr_arb #(
  parameter int unsigned NUM_BANKS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_BANKS-1:0]         req_i,
  input  logic                         adv_i,
  output logic [NUM_BANKS-1:0]         gnt_c_o,
  output logic [$clog2(NUM_BANKS)-1:0] idx_c_o
);
  localparam int unsigned IDX_W = $clog2(NUM_BANKS);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  // First requester at or after the pointer; index wraps by truncation
  always_comb begin
    gnt_c_o = '0;
    idx_c_o = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      cand = ptr_q + IDX_W'(i);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        gnt_c_o[cand] = 1'b1;
        idx_c_o       = cand;
      end
    end
    ptr_d = adv_i ? idx_c_o + IDX_W'(1) : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/ddr_cmd_scheduler.sv
// Shares one DFI command bus between NUM_BANKS bank controllers.
// Grants at most one request per cycle (REF > RD/WR > ACT > PRE, round-robin
// within a class) under tRRD/tCCD/tWTR/tRTW, and drives the registered command
// one cycle after the grant.
//   clk, rst_n                  : clock, synchronous active-low reset
//   sched                       : per-bank req/gnt/ra/ca (slave modport)
//   t_rrd/t_ccd/t_wtr/t_rtw     : static timing values in cycles
//   cke..addr, odt              : DFI command bus
// Optional: define DDR_SCHED_ODT_EN to drive odt for ODT_CYCLES after each WR.
module ddr_cmd_scheduler
  import ddr_sched_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned ODT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ddr_cmd_scheduler_if.slave sched,
  input  logic [T_W-1:0]    t_rrd,
  input  logic [T_W-1:0]    t_ccd,
  input  logic [T_W-1:0]    t_wtr,
  input  logic [T_W-1:0]    t_rtw,
  output logic              cke,
  output logic              cs_n,
  output logic              ras_n,
  output logic              cas_n,
  output logic              we_n,
  output logic [BA_W-1:0]   ba,
  output logic [ADDR_W-1:0] addr,
  output logic              odt
);
  localparam int unsigned IDX_W = $clog2(NUM_BANKS);

  logic [T_W-1:0] rrd_q, ccd_q, wtr_q, rtw_q;
  logic [T_W-1:0] rrd_d, ccd_d, wtr_d, rtw_d;
  logic           cke_q, cs_n_q, cke_d, cs_n_d;
  logic [2:0]     rcw_q, rcw_d;
  logic [BA_W-1:0]   ba_q, ba_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [NUM_BANKS-1:0] rd_m, wr_m, cas_m, act_m;
  logic [NUM_BANKS-1:0] cas_oh, act_oh, pre_oh;
  logic [IDX_W-1:0]     cas_idx, act_idx, pre_idx, sel_idx;
  logic ref_win, cas_win, act_win, pre_win, rd_win, wr_win;
  cmd_t cmd;
  logic [RA_W-1:0] ra_sel;
  logic [CA_W-1:0] ca_sel;

  // Timing-eligibility masks; ineligible requests drop out before arbitration
  assign act_m = (rrd_q == '0) ? sched.act_req : '0;
  assign rd_m  = (ccd_q == '0 && wtr_q == '0) ? sched.rd_req : '0;
  assign wr_m  = (ccd_q == '0 && rtw_q == '0) ? sched.wr_req : '0;
  assign cas_m = rd_m | wr_m;

  // Class priority; everything is suppressed while reset is asserted
  assign ref_win = rst_n && (&sched.ref_req);
  assign cas_win = rst_n && !ref_win && (|cas_m);
  assign act_win = rst_n && !ref_win && !(|cas_m) && (|act_m);
  assign pre_win = rst_n && !ref_win && !(|cas_m) && !(|act_m) && (|sched.pre_req);

  ddr_sched_rr_arb #(.NUM_BANKS(NUM_BANKS)) u_arb_cas (
    .clk(clk), .rst_n(rst_n), .req_i(cas_m), .adv_i(cas_win),
    .gnt_c_o(cas_oh), .idx_c_o(cas_idx));
  ddr_sched_rr_arb #(.NUM_BANKS(NUM_BANKS)) u_arb_act (
    .clk(clk), .rst_n(rst_n), .req_i(act_m), .adv_i(act_win),
    .gnt_c_o(act_oh), .idx_c_o(act_idx));
  ddr_sched_rr_arb #(.NUM_BANKS(NUM_BANKS)) u_arb_pre (
    .clk(clk), .rst_n(rst_n), .req_i(sched.pre_req), .adv_i(pre_win),
    .gnt_c_o(pre_oh), .idx_c_o(pre_idx));

  // A bank holding both RD and WR at the CAS winner position issues the RD
  assign sched.ref_gnt = ref_win ? '1 : '0;
  assign sched.rd_gnt  = cas_win ? (cas_oh & rd_m) : '0;
  assign sched.wr_gnt  = cas_win ? (cas_oh & wr_m & ~rd_m) : '0;
  assign sched.act_gnt = act_win ? act_oh : '0;
  assign sched.pre_gnt = pre_win ? pre_oh : '0;
  assign rd_win = |sched.rd_gnt;
  assign wr_win = |sched.wr_gnt;

  // Next command and bus contents; ba/addr hold through NOPs
  always_comb begin
    cmd     = NOP;
    sel_idx = '0;
    if (ref_win) begin
      cmd = REF;
    end else if (cas_win) begin
      cmd     = rd_win ? RD : WR;
      sel_idx = cas_idx;
    end else if (act_win) begin
      cmd     = ACT;
      sel_idx = act_idx;
    end else if (pre_win) begin
      cmd     = PRE;
      sel_idx = pre_idx;
    end
    ra_sel = sched.ra[32'(sel_idx)*RA_W +: RA_W];
    ca_sel = sched.ca[32'(sel_idx)*CA_W +: CA_W];
    ba_d   = ba_q;
    addr_d = addr_q;
    case (cmd)
      ACT: begin
        ba_d   = BA_W'(sel_idx);
        addr_d = ADDR_W'(ra_sel);
      end
      RD, WR: begin
        ba_d            = BA_W'(sel_idx);
        addr_d          = ADDR_W'(ca_sel);
        addr_d[A10_BIT] = 1'b0;
      end
      PRE: begin
        ba_d   = BA_W'(sel_idx);
        addr_d = '0;
      end
      REF: begin
        ba_d   = '0;
        addr_d = '0;
      end
      default: ;
    endcase
    rcw_d  = cmd_rcw(cmd);
    cs_n_d = 1'b0;
    cke_d  = 1'b1;
    // Load beats decrement; counters saturate at zero
    rrd_d = act_win ? t_load(t_rrd) : ((rrd_q != '0) ? rrd_q - T_W'(1) : '0);
    ccd_d = cas_win ? t_load(t_ccd) : ((ccd_q != '0) ? ccd_q - T_W'(1) : '0);
    wtr_d = wr_win  ? t_load(t_wtr) : ((wtr_q != '0) ? wtr_q - T_W'(1) : '0);
    rtw_d = rd_win  ? t_load(t_rtw) : ((rtw_q != '0) ? rtw_q - T_W'(1) : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cke_q  <= 1'b0;
      cs_n_q <= 1'b1;
      rcw_q  <= RCW_NOP;
      ba_q   <= '0;
      addr_q <= '0;
      rrd_q  <= '0;
      ccd_q  <= '0;
      wtr_q  <= '0;
      rtw_q  <= '0;
    end else begin
      cke_q  <= cke_d;
      cs_n_q <= cs_n_d;
      rcw_q  <= rcw_d;
      ba_q   <= ba_d;
      addr_q <= addr_d;
      rrd_q  <= rrd_d;
      ccd_q  <= ccd_d;
      wtr_q  <= wtr_d;
      rtw_q  <= rtw_d;
    end
  end

  assign cke   = cke_q;
  assign cs_n  = cs_n_q;
  assign ras_n = rcw_q[2];
  assign cas_n = rcw_q[1];
  assign we_n  = rcw_q[0];
  assign ba    = ba_q;
  assign addr  = addr_q;

`ifdef DDR_SCHED_ODT_EN
  localparam int unsigned ODT_W = $clog2(ODT_CYCLES + 1);
  logic [ODT_W-1:0] odt_cnt_q, odt_cnt_d;

  // Each WR (re)starts the ODT window
  always_comb begin
    odt_cnt_d = wr_win ? ODT_W'(ODT_CYCLES)
                       : ((odt_cnt_q != '0) ? odt_cnt_q - ODT_W'(1) : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) odt_cnt_q <= '0;
    else        odt_cnt_q <= odt_cnt_d;
  end

  assign odt = (odt_cnt_q != '0);
`else
  assign odt = 1'b0;
`endif
endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Randomized self-checking bench for ddr_cmd_scheduler against a
// cycle-count reference model of the arbitration and timing rules.
module tb_ddr_cmd_scheduler;
  import ddr_sched_pkg::*;

  localparam int NB  = 4;
  localparam int ODT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr_cmd_scheduler_if #(.NUM_BANKS(NB)) bus ();

  logic [T_W-1:0]    t_rrd, t_ccd, t_wtr, t_rtw;
  logic              cke, cs_n, ras_n, cas_n, we_n, odt;
  logic [BA_W-1:0]   ba;
  logic [ADDR_W-1:0] addr;

  ddr_cmd_scheduler #(.NUM_BANKS(NB), .ODT_CYCLES(ODT)) dut (
    .clk(clk), .rst_n(rst_n), .sched(bus),
    .t_rrd(t_rrd), .t_ccd(t_ccd), .t_wtr(t_wtr), .t_rtw(t_rtw),
    .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr), .odt(odt));

  int n_tests = 0;
  int n_fail  = 0;

  // Bank controller model: -1 idle, 0 ACT, 1 RD, 2 WR, 3 PRE
  int              pend[NB];
  logic [RA_W-1:0] p_ra[NB];
  logic [CA_W-1:0] p_ca[NB];
  logic [NB-1:0]   ref_v;

  // Reference model state: last grant cycle per constraint, RR pointers
  int cyc, last_act, last_cas, last_rd, last_wr;
  int ptr_act, ptr_cas, ptr_pre;
  logic [BA_W-1:0]   m_ba;
  logic [ADDR_W-1:0] m_addr;
  logic [22:0]       exp_dfi;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [22:0] dfi_word();
    return {cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt};
  endfunction

  function automatic logic [19:0] gnt_word();
    return {bus.ref_gnt, bus.rd_gnt, bus.wr_gnt, bus.act_gnt, bus.pre_gnt};
  endfunction

  // Minimum spacing in cycles between two constrained commands
  function automatic int gap(input logic [T_W-1:0] t);
    return (t == '0) ? 1 : int'(t);
  endfunction

  function automatic int rr_pick(input logic [NB-1:0] m, input int ptr);
    for (int i = 0; i < NB; i++)
      if (m[(ptr + i) % NB]) return (ptr + i) % NB;
    return -1;
  endfunction

  task automatic drive_bus();
    for (int b = 0; b < NB; b++) begin
      bus.act_req[b] = (pend[b] == 0);
      bus.rd_req[b]  = (pend[b] == 1);
      bus.wr_req[b]  = (pend[b] == 2);
      bus.pre_req[b] = (pend[b] == 3);
      bus.ra[b*RA_W +: RA_W] = p_ra[b];
      bus.ca[b*CA_W +: CA_W] = p_ca[b];
    end
    bus.ref_req = ref_v;
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) pend[b] = -1;
    ref_v    = '0;
    last_act = -100; last_cas = -100; last_rd = -100; last_wr = -100;
    ptr_act  = 0; ptr_cas = 0; ptr_pre = 0;
    m_ba     = '0; m_addr = '0;
  endtask

  // Reset for 3 cycles with every request raised, then release and expect NOP
  task automatic do_reset();
    rst_n = 1'b0;
    bus.act_req = '1; bus.rd_req = '1; bus.wr_req = '1;
    bus.pre_req = '1; bus.ref_req = '1;
    t_rrd = T_W'($urandom_range(0, 6));
    t_ccd = T_W'($urandom_range(0, 4));
    t_wtr = T_W'($urandom_range(0, 6));
    t_rtw = T_W'($urandom_range(0, 5));
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_dfi", 64'(dfi_word()), 64'({1'b0, 1'b1, 3'b111, 3'd0, 14'd0, 1'b0}));
      check("rst_gnt", 64'(gnt_word()), 64'd0);
    end
    model_reset();
    drive_bus();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_dfi", 64'(dfi_word()), 64'({1'b1, 1'b0, 3'b111, 3'd0, 14'd0, 1'b0}));
  endtask

  task automatic run_cycle();
    logic [NB-1:0] m_act, m_rd, m_wr, m_pre;
    logic [NB-1:0] e_act, e_rd, e_wr, e_pre, e_ref;
    logic [2:0]    rcw;
    logic          e_odt;
    int            w;
    bool_t_dummy: begin end
    // New requests for idle banks; ref is a per-cycle broadcast
    for (int b = 0; b < NB; b++) begin
      if (pend[b] < 0 && $urandom_range(0, 2) == 0) begin
        pend[b] = int'($urandom_range(0, 3));
        p_ra[b] = RA_W'($urandom);
        p_ca[b] = CA_W'($urandom);
      end
    end
    if ($urandom_range(0, 11) == 0)     ref_v = '1;
    else if ($urandom_range(0, 5) == 0) ref_v = NB'($urandom_range(0, 2**NB - 2));
    else                                ref_v = '0;
    drive_bus();
    #1;
    for (int b = 0; b < NB; b++) begin
      m_act[b] = (pend[b] == 0) && (cyc - last_act >= gap(t_rrd));
      m_rd[b]  = (pend[b] == 1) && (cyc - last_cas >= gap(t_ccd)) && (cyc - last_wr >= gap(t_wtr));
      m_wr[b]  = (pend[b] == 2) && (cyc - last_cas >= gap(t_ccd)) && (cyc - last_rd >= gap(t_rtw));
      m_pre[b] = (pend[b] == 3);
    end
    e_act = '0; e_rd = '0; e_wr = '0; e_pre = '0; e_ref = '0;
    rcw = RCW_NOP;
    if (&ref_v) begin
      e_ref = '1; rcw = RCW_REF; m_ba = '0; m_addr = '0;
    end else if (|(m_rd | m_wr)) begin
      w = rr_pick(m_rd | m_wr, ptr_cas);
      ptr_cas = (w + 1) % NB;
      last_cas = cyc;
      m_ba = BA_W'(w);
      m_addr = ADDR_W'(p_ca[w]);
      if (pend[w] == 1) begin e_rd[w] = 1'b1; rcw = RCW_RD; last_rd = cyc; end
      else              begin e_wr[w] = 1'b1; rcw = RCW_WR; last_wr = cyc; end
      pend[w] = -1;
    end else if (|m_act) begin
      w = rr_pick(m_act, ptr_act);
      ptr_act = (w + 1) % NB; last_act = cyc;
      e_act[w] = 1'b1; rcw = RCW_ACT;
      m_ba = BA_W'(w); m_addr = ADDR_W'(p_ra[w]);
      pend[w] = -1;
    end else if (|m_pre) begin
      w = rr_pick(m_pre, ptr_pre);
      ptr_pre = (w + 1) % NB;
      e_pre[w] = 1'b1; rcw = RCW_PRE;
      m_ba = BA_W'(w); m_addr = '0;
      pend[w] = -1;
    end
    check("gnt", 64'(gnt_word()), 64'({e_ref, e_rd, e_wr, e_act, e_pre}));
`ifdef DDR_SCHED_ODT_EN
    e_odt = (cyc + 1 - last_wr >= 1) && (cyc + 1 - last_wr <= ODT);
`else
    e_odt = 1'b0;
`endif
    exp_dfi = {1'b1, 1'b0, rcw, m_ba, m_addr, e_odt};
    @(posedge clk); #1;
    cyc++;
    check("dfi", 64'(dfi_word()), 64'(exp_dfi));
  endtask

  initial begin
    cyc = 0;
    model_reset();
    for (int ph = 0; ph < 5; ph++) begin
      do_reset();
      for (int n = 0; n < 300; n++) run_cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
